// File: rtl/irq_controller_if.sv
// -----------------------------------------------------------------------------
// irq_controller_if
// Groups the interrupt-source, mask-register and cpu handshake signals that
// pass between the interrupt controller and its surroundings.
//   irq_in     raw request lines, one per interrupt source
//   mask_we    mask register write strobe
//   mask_data  new mask value, 1 = line enabled
//   mask_q     current mask register
//   pending_q  current pending register
//   int_req    interrupt request towards the cpu
//   int_idx    index of the requested line, valid while int_req = 1
//   int_ack    cpu accepts the request (one-cycle pulse)
//   int_done   cpu finished the ISR (one-cycle pulse)
// Modports: slave = controller side, master = cpu / source side.
// -----------------------------------------------------------------------------
interface irq_controller_if #(
    parameter int N_IRQ = 8,
    parameter int IDX_W = 3
);
    logic [N_IRQ-1:0] irq_in;
    logic             mask_we;
    logic [N_IRQ-1:0] mask_data;
    logic [N_IRQ-1:0] mask_q;
    logic [N_IRQ-1:0] pending_q;
    logic             int_req;
    logic [IDX_W-1:0] int_idx;
    logic             int_ack;
    logic             int_done;

    modport slave (
        input  irq_in, mask_we, mask_data, int_ack, int_done,
        output mask_q, pending_q, int_req, int_idx
    );

    modport master (
        output irq_in, mask_we, mask_data, int_ack, int_done,
        input  mask_q, pending_q, int_req, int_idx
    );
endinterface

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
// Edge-detects and latches interrupt requests, applies a software mask and
// presents the lowest-index eligible line to the cpu with a req/ack handshake.
// No new request is issued until the cpu signals end-of-service (int_done).
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   reset  asynchronous, active-low; 0 clears all state immediately
//   bus    irq_controller_if.slave (request lines, mask register, pending
//          register, int_req/int_idx/int_ack/int_done handshake)
//
// Optional feature: define IRQ_SYNC_EN to pass irq_in through a 2-flop
// synchronizer before edge detection (adds 2 cycles of latency). Without it
// irq_in must already be synchronous to clk.
// -----------------------------------------------------------------------------
module irq_controller #(
    parameter int N_IRQ = 8,
    parameter int IDX_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    irq_controller_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N_IRQ-1:0] r_mask;
    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] r_irq_prev;
    logic             r_int_req;
    logic [IDX_W-1:0] r_int_idx;
    logic             w_req_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_clr_en;
    logic [N_IRQ-1:0] w_irq_s;
    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_clr;
    logic [N_IRQ-1:0] w_eligible;

    // Lowest set index wins; scanning downward lets the lowest hit overwrite.
    function automatic logic [IDX_W-1:0] f_lowest_idx(input logic [N_IRQ-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

`ifdef IRQ_SYNC_EN
    logic [N_IRQ-1:0] r_sync_p0;
    logic [N_IRQ-1:0] r_sync_p1;

    // ---- stage p0/p1: two-flop synchronizer ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
        end else begin
            r_sync_p0 <= bus.irq_in;
            r_sync_p1 <= r_sync_p0;
        end
    end
    assign w_irq_s = r_sync_p1;
`else
    assign w_irq_s = bus.irq_in;
`endif

    // History resets to 0, so a line already high at reset release is an edge.
    assign w_rise     = w_irq_s & ~r_irq_prev;
    assign w_eligible = r_pending & r_mask;
    assign w_clr      = w_clr_en ? (N_IRQ'(1) << r_int_idx) : '0;

    // ---- edge detect, pending and mask registers ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_prev <= '0;
            r_pending  <= '0;
            r_mask     <= '0;
        end else begin
            r_irq_prev <= w_irq_s;
            // A new edge on the line being acked outranks the clear.
            r_pending  <= (r_pending & ~w_clr) | w_rise;
            if (bus.mask_we) r_mask <= bus.mask_data;
        end
    end

    // ---- FSM state and registered handshake outputs ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_int_req <= 1'b0;
            r_int_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_int_req <= w_req_nxt;
            r_int_idx <= w_idx_nxt;
        end
    end

    // Request/index stay frozen in REQ; only ack releases them, and ack
    // takes precedence over a simultaneous done.
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_int_req;
        w_idx_nxt   = r_int_idx;
        w_clr_en    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (|w_eligible) begin
                    w_state_nxt = S_REQ;
                    w_req_nxt   = 1'b1;
                    w_idx_nxt   = f_lowest_idx(w_eligible);
                end
            end
            S_REQ: begin
                if (bus.int_ack) begin
                    w_state_nxt = S_SERVICE;
                    w_req_nxt   = 1'b0;
                    w_clr_en    = 1'b1;
                end
            end
            S_SERVICE: begin
                if (bus.int_done) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    assign bus.mask_q    = r_mask;
    assign bus.pending_q = r_pending;
    assign bus.int_req   = r_int_req;
    assign bus.int_idx   = r_int_idx;

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

    localparam int N_IRQ = 8;
    localparam int IDX_W = 3;
`ifdef IRQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    irq_controller_if #(.N_IRQ(N_IRQ), .IDX_W(IDX_W)) bus ();

    irq_controller #(.N_IRQ(N_IRQ), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] irq;
        logic       mwe;
        logic [7:0] mdata;
        logic       ack;
        logic       done;
        logic       exp_req;
        logic [2:0] exp_idx;
        logic [7:0] exp_pend;
        logic [7:0] exp_mask;
    } vec_t;

    vec_t tbl [25];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.irq_in    = '0;
        bus.mask_we   = 1'b0;
        bus.mask_data = '0;
        bus.int_ack   = 1'b0;
        bus.int_done  = 1'b0;
    endtask

    task automatic wait_req(input int budget, input string name);
        for (int i = 0; i < budget && !bus.int_req; i++) step();
        checks++;
        if (!bus.int_req) begin
            errors++;
            $display("FAIL %s: int_req never rose within %0d cycles", name, budget);
        end
    endtask

    initial begin
        int   reqs;
        logic prev_req;
        logic acked;

        //                irq    mwe   mdata  ack   done  req   idx   pend   mask
        tbl[0]  = '{8'h04, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h04, 8'h00};
        tbl[1]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h04, 8'h00};
        tbl[2]  = '{8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 8'h04, 8'hFF};
        tbl[3]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 8'hFF};
        tbl[4]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 8'hFF};
        tbl[5]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00, 8'hFF};
        tbl[6]  = '{8'h81, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 8'h81, 8'hFF};
        tbl[7]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 8'h81, 8'hFF};
        tbl[8]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h80, 8'hFF};
        tbl[9]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h80, 8'hFF};
        tbl[10] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd7, 8'h80, 8'hFF};
        tbl[11] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd7, 8'h00, 8'hFF};
        tbl[12] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd7, 8'h00, 8'hFF};
        tbl[13] = '{8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd7, 8'h20, 8'hFF};
        tbl[14] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20, 8'hFF};
        tbl[15] = '{8'h02, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 8'h22, 8'hFF};
        tbl[16] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 8'h22, 8'hFF};
        tbl[17] = '{8'h00, 1'b1, 8'hDF, 1'b0, 1'b0, 1'b1, 3'd5, 8'h22, 8'hDF};
        tbl[18] = '{8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd5, 8'h22, 8'hFF};
        tbl[19] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd5, 8'h02, 8'hFF};
        tbl[20] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd5, 8'h02, 8'hFF};
        tbl[21] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 8'h02, 8'hFF};
        tbl[22] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd1, 8'h00, 8'hFF};
        tbl[23] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd1, 8'h00, 8'hFF};
        tbl[24] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd1, 8'h00, 8'hFF};

        idle_inputs();
        reset = 1'b0;
        #12;
        chk("reset int_req",   8'(bus.int_req), 8'h00);
        chk("reset mask_q",    bus.mask_q,      8'h00);
        chk("reset pending_q", bus.pending_q,   8'h00);
        chk("reset int_idx",   8'(bus.int_idx), 8'h00);
        @(negedge clk);
        reset = 1'b1;

`ifndef IRQ_SYNC_EN
        for (int v = 0; v < 25; v++) begin
            bus.irq_in    = tbl[v].irq;
            bus.mask_we   = tbl[v].mwe;
            bus.mask_data = tbl[v].mdata;
            bus.int_ack   = tbl[v].ack;
            bus.int_done  = tbl[v].done;
            step();
            chk($sformatf("vec%0d int_req", v),   8'(bus.int_req), 8'(tbl[v].exp_req));
            chk($sformatf("vec%0d int_idx", v),   8'(bus.int_idx), 8'(tbl[v].exp_idx));
            chk($sformatf("vec%0d pending_q", v), bus.pending_q,   tbl[v].exp_pend);
            chk($sformatf("vec%0d mask_q", v),    bus.mask_q,      tbl[v].exp_mask);
        end
        idle_inputs();
`else
        // Synchronized build: irq edge at edge k -> pending at k+2, req after k+3.
        bus.mask_we = 1'b1; bus.mask_data = 8'hFF;
        step();
        bus.mask_we = 1'b0;
        bus.irq_in = 8'h04;
        step();
        bus.irq_in = 8'h00;
        chk("sync pending k",   bus.pending_q, 8'h00);
        step();
        chk("sync pending k+1", bus.pending_q, 8'h00);
        step();
        chk("sync pending k+2", bus.pending_q, 8'h04);
        chk("sync req k+2",     8'(bus.int_req), 8'h00);
        step();
        chk("sync req k+3",     8'(bus.int_req), 8'h01);
        chk("sync idx k+3",     8'(bus.int_idx), 8'h02);
        bus.int_ack = 1'b1;  step(); bus.int_ack = 1'b0;
        bus.int_done = 1'b1; step(); bus.int_done = 1'b0;
        step();
`endif

        // Held line: one request only, across repeated ack/done rounds.
        reqs     = 0;
        prev_req = 1'b0;
        acked    = 1'b0;
        bus.irq_in = 8'h08;
        for (int c = 0; c < 20; c++) begin
            bus.int_ack  = 1'b0;
            bus.int_done = 1'b0;
            if (bus.int_req && !prev_req) begin
                reqs++;
                chk("held line idx", 8'(bus.int_idx), 8'h03);
            end
            prev_req = bus.int_req;
            if (acked) begin
                bus.int_done = 1'b1;
                acked = 1'b0;
            end else if (bus.int_req) begin
                bus.int_ack = 1'b1;
                acked = 1'b1;
            end
            step();
        end
        bus.int_ack = 1'b0; bus.int_done = 1'b0;
        chk("held line request count", 8'(reqs), 8'd1);
        chk("held line pending",       bus.pending_q, 8'h00);
        bus.irq_in = 8'h00;
        step(); step();

        // New edge on the acked line in the ack cycle keeps it pending.
        bus.irq_in = 8'h08;
        step();
        bus.irq_in = 8'h00;
        wait_req(10, "pulse3 request");
        chk("pulse3 idx", 8'(bus.int_idx), 8'h03);
        bus.int_ack = 1'b1;
        bus.irq_in  = 8'h08;
        step();
        bus.int_ack = 1'b0;
        bus.irq_in  = 8'h00;
        repeat (LAT) step();
        chk("set wins over clear pending", bus.pending_q, 8'h08);
        chk("set wins req dropped",        8'(bus.int_req), 8'h00);
        bus.int_done = 1'b1;
        step();
        bus.int_done = 1'b0;
        wait_req(10, "re-request after done");
        chk("re-request idx", 8'(bus.int_idx), 8'h03);

        // Async reset while a request is in flight.
        #2;
        bus.irq_in = 8'h40;
        reset = 1'b0;
        #1;
        chk("async reset int_req",   8'(bus.int_req), 8'h00);
        chk("async reset pending_q", bus.pending_q,   8'h00);
        chk("async reset mask_q",    bus.mask_q,      8'h00);
        chk("async reset int_idx",   8'(bus.int_idx), 8'h00);
        #2;
        reset = 1'b1;
        // Line already high at reset release counts as one edge.
        repeat (LAT + 1) step();
        chk("high at release pending", bus.pending_q, 8'h40);
        repeat (3) step();
        chk("high at release masked no req", 8'(bus.int_req), 8'h00);
        chk("high at release still pending", bus.pending_q, 8'h40);
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
